uart_cfg_seq: RTL and testbench
===============================

# uart_cfg_seq

Configuration sequencer for the 16550-style UART. After reset, or on a start request, it programs the UART's divisor latch, line control, FIFO control and interrupt enable registers. It acts as a single write-channel master on the UART's AXI-lite-style register write port (aw/w/b), which is muxed ahead of the CPU path. The block owns the DLAB handshake so software never sees a half-configured divisor.

## Interface
- DEFAULT_DIV, 16'd27: divisor used by auto-start; {DLM,DLL}.
- DEFAULT_LCR, 8'h03: line control used by auto-start (8N1); bit 7 ignored.
- DEFAULT_FCR, 8'h07: FIFO control used by auto-start.
- DEFAULT_IER, 8'h01: interrupt enable used by auto-start.
- AUTO_START, 1: when 1, the sequence runs once automatically after reset.
- TIMEOUT, 255: maximum cycles spent in one write (address/data plus response) before abort; must be ≥ 2.
- clk_i  in  1  single clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle request; latches div_i/lcr_i/fcr_i/ier_i and starts a sequence.
- div_i  in  16  baud divisor.
- lcr_i, fcr_i, ier_i  in  8 each  register values; lcr_i[7] ignored.
- busy_o  out  1  high from the cycle after acceptance until the cycle done_o or err_o is set.
- done_o  out  1  one-cycle pulse on successful completion.
- err_o  out  1  sticky abort flag; cleared by reset or by an accepted start_i.
- err_step_o  out  3  index (0-5) of the step that failed; valid while err_o is high.
- awvalid_o  out  1; awaddr_o  out  3; awready_i  in  1.
- wvalid_o  out  1; wdata_o  out  8; wready_i  in  1.
- bvalid_i  in  1; bresp_i  in  2; bready_o  out  1.

## Operation
- Write sequence, in this step order:
  - step 0: addr 3 ← {1,lcr[6:0]} (DLAB=1)
  - step 1: addr 0 ← div[7:0]
  - step 2: addr 1 ← div[15:8]
  - step 3: addr 3 ← {0,lcr[6:0]}
  - step 4: addr 2 ← fcr
  - step 5: addr 1 ← ier
- A div value of 0 is replaced by 16'd1 at latch time.
- FSM states: IDLE, WADDR, WRESP, ABORT.
  - IDLE: busy_o=0. An accepted start (start_i, or the auto-start pulse) latches the operands, clears err_o, sets step=0, and moves to WADDR.
  - WADDR: awvalid_o and wvalid_o both assert on entry. Each drops independently in the cycle after its own handshake (valid&ready). Once both handshakes have completed (same or different cycles), go to WRESP.
  - WRESP: bready_o=1. On bvalid_i with bresp_i==2'b00: if step==5, go to IDLE and pulse done_o; otherwise step+1 and go to WADDR. On bvalid_i with bresp_i≠00: go to ABORT.
  - ABORT: set err_o=1, err_step_o=step, deassert all valids, go to IDLE next cycle. There is no done_o pulse on abort.
- Timeout: a per-step counter resets on WADDR entry. If it reaches TIMEOUT before the b handshake, go to ABORT. Valids are dropped even if the slave has not accepted them; this is the one permitted AXI-rule exception, documented for the integrator.
- start_i while busy_o=1 is ignored: no relatch, no restart.
- Auto-start fires exactly once, in the first cycle rst_i is low, using the DEFAULT_* values. A start_i in that same cycle takes priority and its operands are used.
- awaddr_o/wdata_o are held stable while their valid is high and are registered, not combinational from the inputs.

## Timing
- Reset values: awvalid_o=0, wvalid_o=0, bready_o=0, busy_o=0, done_o=0, err_o=0, err_step_o=0, awaddr_o=0, wdata_o=0.
- Start accepted in cycle N: busy_o=1, awvalid_o=wvalid_o=1 in cycle N+1.
- Best case (ready high, bvalid in the first WRESP cycle) is 2 cycles per step. done_o occurs at N+13; busy_o=0 in that same cycle.
- rst_i mid-sequence: all outputs return to reset values in the next cycle. The sequence is not resumed. Auto-start reruns if AUTO_START=1.
- The timeout counter is 8 bits wide for the default TIMEOUT and saturates; it never wraps into a false pass.

## Test plan
- Auto-start with an ideal slave (ready=1, bvalid the cycle bready rises): the write log is (3,83)(0,1B)(1,00)(3,03)(2,07)(1,01). done_o pulses at cycle 13 after reset release.
- start_i with div=16'h0000, lcr=8'h9B, fcr=8'hC1, ier=8'h0F: the log is (3,9B)(0,01)(1,00)(3,1B)(2,C1)(1,0F).
- Backpressure with awready delayed 3 cycles and wready delayed 1 cycle: wvalid_o drops after its own handshake and awvalid_o stays high. Data and address are unchanged while valid is high. The step completes correctly.
- bresp=2'b10 on step 2: err_o=1, err_step_o=2, busy_o=0, no done_o pulse, and no further writes. A subsequent start_i clears err_o and the full sequence completes.
- Slave never asserts bvalid with TIMEOUT=10: abort 10 cycles after WADDR entry of step 0. Then err_o=1 and err_step_o=0.
- start_i pulsed mid-sequence, and rst_i at step 3: the start is ignored and the log is unaffected. After reset, outputs are at reset values and auto-start restarts from step 0.

Source files
------------

// File: rtl/uart_cfg_seq.sv
// uart_cfg_seq: programs divisor, LCR, FCR and IER of a 16550-style UART
// over an aw/w/b register write port, owning the DLAB handshake.
module uart_cfg_seq #(
  parameter logic [15:0] DEFAULT_DIV = 16'd27,
  parameter logic [7:0]  DEFAULT_LCR = 8'h03,
  parameter logic [7:0]  DEFAULT_FCR = 8'h07,
  parameter logic [7:0]  DEFAULT_IER = 8'h01,
  parameter bit          AUTO_START  = 1'b1,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] div_i,
  input  logic [7:0]  lcr_i,
  input  logic [7:0]  fcr_i,
  input  logic [7:0]  ier_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [2:0]  err_step_o,
  output logic        awvalid_o,
  output logic [2:0]  awaddr_o,
  input  logic        awready_i,
  output logic        wvalid_o,
  output logic [7:0]  wdata_o,
  input  logic        wready_i,
  input  logic        bvalid_i,
  input  logic [1:0]  bresp_i,
  output logic        bready_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TMO_MAX  = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE, WADDR, WRESP, ABORT
  } state_t;

  state_t          r_state, w_state_n;
  logic [2:0]      r_step, w_step_n;
  logic [15:0]     r_div, w_div_n, w_div_sel;
  logic [6:0]      r_lcr, w_lcr_n;
  logic [7:0]      w_lcr_sel;
  logic [7:0]      r_fcr, w_fcr_n, w_fcr_sel;
  logic [7:0]      r_ier, w_ier_n, w_ier_sel;
  logic [CW-1:0]   r_cnt, w_cnt_n, w_cnt_inc;
  logic            r_awv, w_awv_n;
  logic            r_wv, w_wv_n;
  logic            r_bready, w_bready_n;
  logic [2:0]      r_awaddr, w_awaddr_n;
  logic [7:0]      r_wdata, w_wdata_n;
  logic            r_busy, w_busy_n;
  logic            r_done, w_done_n;
  logic            r_err, w_err_n;
  logic [2:0]      r_err_step, w_err_step_n;
  logic            r_auto;
  logic            w_go, w_abort;
  logic            w_aw_hs, w_w_hs, w_b_hs;
  logic            w_tmo;
  logic            w_unused;

  assign w_unused  = w_lcr_sel[7];
  assign w_aw_hs   = r_awv & awready_i;
  assign w_w_hs    = r_wv & wready_i;
  assign w_b_hs    = r_bready & bvalid_i;
  assign w_tmo     = (r_cnt >= TMO_LAST);
  assign w_cnt_inc = (r_cnt == TMO_MAX) ? r_cnt : r_cnt + 1'b1;

  function automatic logic [2:0] step_addr(input logic [2:0] s);
    unique case (s)
      3'd0:    step_addr = 3'd3;
      3'd1:    step_addr = 3'd0;
      3'd2:    step_addr = 3'd1;
      3'd3:    step_addr = 3'd3;
      3'd4:    step_addr = 3'd2;
      default: step_addr = 3'd1;
    endcase
  endfunction

  function automatic logic [7:0] step_data(
    input logic [2:0]  s,
    input logic [15:0] d,
    input logic [6:0]  l,
    input logic [7:0]  f,
    input logic [7:0]  ie
  );
    unique case (s)
      3'd0:    step_data = {1'b1, l};
      3'd1:    step_data = d[7:0];
      3'd2:    step_data = d[15:8];
      3'd3:    step_data = {1'b0, l};
      3'd4:    step_data = f;
      default: step_data = ie;
    endcase
  endfunction

  always_comb begin
    w_state_n    = r_state;
    w_step_n     = r_step;
    w_div_n      = r_div;
    w_lcr_n      = r_lcr;
    w_fcr_n      = r_fcr;
    w_ier_n      = r_ier;
    w_cnt_n      = w_cnt_inc;
    w_awv_n      = r_awv;
    w_wv_n       = r_wv;
    w_bready_n   = r_bready;
    w_busy_n     = r_busy;
    w_done_n     = 1'b0;
    w_err_n      = r_err;
    w_err_step_n = r_err_step;
    w_awaddr_n   = r_awaddr;
    w_wdata_n    = r_wdata;
    w_go         = 1'b0;
    w_abort      = 1'b0;
    w_div_sel    = DEFAULT_DIV;
    w_lcr_sel    = DEFAULT_LCR;
    w_fcr_sel    = DEFAULT_FCR;
    w_ier_sel    = DEFAULT_IER;
    if (start_i) begin
      w_div_sel = div_i;
      w_lcr_sel = lcr_i;
      w_fcr_sel = fcr_i;
      w_ier_sel = ier_i;
    end
    unique case (r_state)
      IDLE: begin
        if (start_i || r_auto) begin
          w_div_n      = (w_div_sel == 16'd0) ? 16'd1 : w_div_sel;
          w_lcr_n      = w_lcr_sel[6:0];
          w_fcr_n      = w_fcr_sel;
          w_ier_n      = w_ier_sel;
          w_step_n     = 3'd0;
          w_err_n      = 1'b0;
          w_err_step_n = 3'd0;
          w_busy_n     = 1'b1;
          w_go         = 1'b1;
        end
      end
      WADDR: begin
        if (w_aw_hs) w_awv_n = 1'b0;
        if (w_w_hs)  w_wv_n  = 1'b0;
        if (w_tmo) begin
          w_abort = 1'b1;
        end else if ((!r_awv || w_aw_hs) &&
                     (!r_wv || w_w_hs)) begin
          w_state_n  = WRESP;
          w_bready_n = 1'b1;
        end
      end
      WRESP: begin
        if (w_b_hs) begin
          w_bready_n = 1'b0;
          if (bresp_i != 2'b00) begin
            w_abort = 1'b1;
          end else if (r_step == 3'd5) begin
            w_state_n = IDLE;
            w_done_n  = 1'b1;
            w_busy_n  = 1'b0;
          end else begin
            w_step_n = r_step + 3'd1;
            w_go     = 1'b1;
          end
        end else if (w_tmo) begin
          w_abort = 1'b1;
        end
      end
      ABORT:   w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
    if (w_go) begin
      w_state_n  = WADDR;
      w_cnt_n    = '0;
      w_awv_n    = 1'b1;
      w_wv_n     = 1'b1;
      w_awaddr_n = step_addr(w_step_n);
      w_wdata_n  = step_data(w_step_n, w_div_n,
                     w_lcr_n, w_fcr_n, w_ier_n);
    end
    // Timeout drops valids even without a handshake so a dead slave
    // cannot wedge the sequencer.
    if (w_abort) begin
      w_state_n    = ABORT;
      w_awv_n      = 1'b0;
      w_wv_n       = 1'b0;
      w_bready_n   = 1'b0;
      w_busy_n     = 1'b0;
      w_err_n      = 1'b1;
      w_err_step_n = r_step;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_step     <= '0;
      r_div      <= '0;
      r_lcr      <= '0;
      r_fcr      <= '0;
      r_ier      <= '0;
      r_cnt      <= '0;
      r_awv      <= 1'b0;
      r_wv       <= 1'b0;
      r_bready   <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_step <= '0;
      r_auto     <= AUTO_START;
    end else begin
      r_state    <= w_state_n;
      r_step     <= w_step_n;
      r_div      <= w_div_n;
      r_lcr      <= w_lcr_n;
      r_fcr      <= w_fcr_n;
      r_ier      <= w_ier_n;
      r_cnt      <= w_cnt_n;
      r_awv      <= w_awv_n;
      r_wv       <= w_wv_n;
      r_bready   <= w_bready_n;
      r_awaddr   <= w_awaddr_n;
      r_wdata    <= w_wdata_n;
      r_busy     <= w_busy_n;
      r_done     <= w_done_n;
      r_err      <= w_err_n;
      r_err_step <= w_err_step_n;
      r_auto     <= 1'b0;
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign err_step_o = r_err_step;
  assign awvalid_o  = r_awv;
  assign awaddr_o   = r_awaddr;
  assign wvalid_o   = r_wv;
  assign wdata_o    = r_wdata;
  assign bready_o   = r_bready;

endmodule

// File: tb/tb_uart_cfg_seq.sv
// tb_uart_cfg_seq: random-stimulus scoreboard bench for uart_cfg_seq
// with a configurable slave model on the aw/w/b port.
module tb_uart_cfg_seq;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] div_i = '0;
  logic [7:0]  lcr_i = '0;
  logic [7:0]  fcr_i = '0;
  logic [7:0]  ier_i = '0;
  logic        busy_o, done_o, err_o;
  logic [2:0]  err_step_o;
  logic        awvalid_o;
  logic [2:0]  awaddr_o;
  logic        awready_i = 1'b0;
  logic        wvalid_o;
  logic [7:0]  wdata_o;
  logic        wready_i = 1'b0;
  logic        bvalid_i = 1'b0;
  logic [1:0]  bresp_i = '0;
  logic        bready_o;

  uart_cfg_seq #(.TIMEOUT(10)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .div_i(div_i), .lcr_i(lcr_i), .fcr_i(fcr_i),
    .ier_i(ier_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .err_step_o(err_step_o),
    .awvalid_o(awvalid_o), .awaddr_o(awaddr_o),
    .awready_i(awready_i), .wvalid_o(wvalid_o),
    .wdata_o(wdata_o), .wready_i(wready_i),
    .bvalid_i(bvalid_i), .bresp_i(bresp_i),
    .bready_o(bready_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit is_err;
    int step;
    int lat;
  } out_t;

  logic [10:0] exp_q[$];
  out_t        out_q[$];
  logic [2:0]  pa_q[$];
  logic [7:0]  pd_q[$];
  int          nwrites = 0;

  bit rnd_mode = 0;
  int aw_fix = 0, w_fix = 0, b_fix = 0;
  int err_at = -1, to_at = -1;
  int slv_idx = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: the six register writes the UART must receive.
  function automatic void push_seq(input logic [15:0] dv,
                                   input logic [7:0] l,
                                   input logic [7:0] f,
                                   input logic [7:0] ie,
                                   input int n);
    logic [15:0] d;
    logic [10:0] w[6];
    d = (dv == 16'd0) ? 16'd1 : dv;
    w[0] = {3'd3, 1'b1, l[6:0]};
    w[1] = {3'd0, d[7:0]};
    w[2] = {3'd1, d[15:8]};
    w[3] = {3'd3, 1'b0, l[6:0]};
    w[4] = {3'd2, f};
    w[5] = {3'd1, ie};
    for (int i = 0; i < n; i++) exp_q.push_back(w[i]);
  endfunction

  function automatic void push_out(input bit e, input int s,
                                   input int lat);
    out_t o;
    o.is_err = e;
    o.step = s;
    o.lat = lat;
    out_q.push_back(o);
  endfunction

  // Slave model: drives readies/bvalid at negedge.
  int aw_cnt, w_cnt, b_cnt, aw_d, w_d, b_d;
  bit aw_act = 0, w_act = 0, b_act = 0;
  always @(negedge clk_i) begin
    if (rst_i) begin
      awready_i = 0; wready_i = 0; bvalid_i = 0;
      bresp_i = 0; aw_act = 0; w_act = 0; b_act = 0;
      slv_idx = 0;
    end else begin
      if (awvalid_o) begin
        if (!aw_act) begin
          aw_act = 1; aw_cnt = 0;
          aw_d = rnd_mode ? int'($urandom_range(0, 3)) : aw_fix;
        end
        awready_i = (aw_cnt >= aw_d);
        if (awready_i) aw_act = 0; else aw_cnt++;
      end else begin
        awready_i = 0; aw_act = 0;
      end
      if (wvalid_o) begin
        if (!w_act) begin
          w_act = 1; w_cnt = 0;
          w_d = rnd_mode ? int'($urandom_range(0, 3)) : w_fix;
        end
        wready_i = (w_cnt >= w_d);
        if (wready_i) w_act = 0; else w_cnt++;
      end else begin
        wready_i = 0; w_act = 0;
      end
      if (bready_o && slv_idx != to_at) begin
        if (!b_act) begin
          b_act = 1; b_cnt = 0;
          b_d = rnd_mode ? int'($urandom_range(0, 3)) : b_fix;
        end
        bvalid_i = (b_cnt >= b_d);
        bresp_i = (slv_idx == err_at) ? 2'b10 : 2'b00;
        if (bvalid_i) begin
          b_act = 0; slv_idx++;
        end else b_cnt++;
      end else begin
        bvalid_i = 0; b_act = 0;
      end
    end
  end

  // Monitor: samples 1ns after negedge, pops scoreboard entries.
  logic p_awv = 0, p_wv = 0, p_awhs = 0, p_whs = 0;
  logic p_busy = 0, p_err = 0;
  logic [2:0] p_aa = '0;
  logic [7:0] p_wd = '0;
  int cyc = 0, t_start = 0;
  always @(negedge clk_i) begin
    logic [10:0] got, e;
    out_t o;
    #1;
    cyc++;
    if (rst_i) begin
      pa_q.delete(); pd_q.delete();
      p_awv = 0; p_wv = 0; p_awhs = 0; p_whs = 0;
      p_busy = 0; p_err = 0;
    end else begin
      if (p_awv && !p_awhs)
        chk("aw_hold", (awvalid_o && awaddr_o == p_aa) || err_o, 1);
      if (p_wv && !p_whs)
        chk("w_hold", (wvalid_o && wdata_o == p_wd) || err_o, 1);
      if (p_awhs) chk("aw_drop", awvalid_o, 0);
      if (p_whs)  chk("w_drop", wvalid_o, 0);
      if (awvalid_o && awready_i) pa_q.push_back(awaddr_o);
      if (wvalid_o && wready_i)   pd_q.push_back(wdata_o);
      if (bready_o && bvalid_i) begin
        nwrites++;
        if (pa_q.size() == 0 || pd_q.size() == 0 ||
            exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL write_unexpected actual=%0d/%0d required=%0d",
                   pa_q.size(), pd_q.size(), exp_q.size());
        end else begin
          got[10:8] = pa_q.pop_front();
          got[7:0] = pd_q.pop_front();
          e = exp_q.pop_front();
          chk("write", got, e);
        end
      end
      if (busy_o && !p_busy) t_start = cyc;
      if (done_o || (err_o && !p_err)) begin
        if (out_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL end_unexpected actual=%0d/%0d required=none",
                   done_o, err_o);
        end else begin
          o = out_q.pop_front();
          chk("end_kind", err_o, o.is_err);
          if (o.is_err) chk("err_step", err_step_o, o.step);
          if (o.lat >= 0) chk("latency", cyc - t_start, o.lat);
          chk("busy_end", busy_o, 0);
          chk("log_len", exp_q.size(), 0);
        end
        pa_q.delete(); pd_q.delete();
      end
      p_awv = awvalid_o; p_awhs = awvalid_o && awready_i;
      p_wv = wvalid_o; p_whs = wvalid_o && wready_i;
      p_aa = awaddr_o; p_wd = wdata_o;
      p_busy = busy_o; p_err = err_o;
    end
  end

  task automatic chk_rst();
    chk("rst_awvalid", awvalid_o, 0);
    chk("rst_wvalid", wvalid_o, 0);
    chk("rst_bready", bready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_err_step", err_step_o, 0);
    chk("rst_awaddr", awaddr_o, 0);
    chk("rst_wdata", wdata_o, 0);
  endtask

  task automatic wait_end();
    int k = 0;
    while (out_q.size() != 0 && k < 500) begin
      @(negedge clk_i); k++;
    end
    chk("seq_end", out_q.size(), 0);
    out_q.delete();
    repeat (3) @(negedge clk_i);
    chk("log_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_start(input logic [15:0] dv, input logic [7:0] l,
                          input logic [7:0] f, input logic [7:0] ie);
    start_i = 1; div_i = dv; lcr_i = l; fcr_i = f; ier_i = ie;
    slv_idx = 0;
    @(negedge clk_i);
    start_i = 0;
    div_i = 16'($urandom); lcr_i = 8'($urandom);
    fcr_i = 8'($urandom); ier_i = 8'($urandom);
    chk("busy_on", busy_o, 1);
    chk("err_clr", err_o, 0);
  endtask

  initial begin
    logic [15:0] dv;
    logic [7:0] l, f, ie;
    int r, n, base, k;
    push_seq(16'd27, 8'h03, 8'h07, 8'h01, 6);
    push_out(0, 0, 12);
    repeat (2) @(negedge clk_i);
    chk_rst();
    rst_i = 0;
    wait_end();

    push_seq(16'h0000, 8'h9B, 8'hC1, 8'h0F, 6);
    push_out(0, 0, 12);
    do_start(16'h0000, 8'h9B, 8'hC1, 8'h0F);
    wait_end();

    aw_fix = 3; w_fix = 1; b_fix = 0;
    dv = 16'($urandom); l = 8'($urandom);
    f = 8'($urandom); ie = 8'($urandom);
    push_seq(dv, l, f, ie, 6);
    push_out(0, 0, 30);
    do_start(dv, l, f, ie);
    wait_end();
    aw_fix = 0; w_fix = 0;

    err_at = 2;
    dv = 16'($urandom); l = 8'($urandom);
    f = 8'($urandom); ie = 8'($urandom);
    push_seq(dv, l, f, ie, 3);
    push_out(1, 2, 6);
    do_start(dv, l, f, ie);
    wait_end();
    chk("err_sticky", err_o, 1);
    chk("err_step_hold", err_step_o, 2);
    err_at = -1;
    push_seq(dv, l, f, ie, 6);
    push_out(0, 0, 12);
    do_start(dv, l, f, ie);
    wait_end();

    to_at = 0;
    push_out(1, 0, 10);
    do_start(16'h1234, 8'h1B, 8'h00, 8'h00);
    wait_end();
    chk("tmo_err", err_o, 1);
    to_at = -1;

    rnd_mode = 1;
    for (int i = 0; i < 12; i++) begin
      dv = ($urandom % 4 == 0) ? 16'd0 : 16'($urandom);
      l = 8'($urandom); f = 8'($urandom); ie = 8'($urandom);
      r = $urandom % 6;
      if (r == 0) begin
        err_at = $urandom % 6; n = err_at + 1;
        push_out(1, err_at, -1);
      end else if (r == 1) begin
        to_at = $urandom % 6; n = to_at;
        push_out(1, to_at, -1);
      end else begin
        n = 6;
        push_out(0, 0, -1);
      end
      push_seq(dv, l, f, ie, n);
      do_start(dv, l, f, ie);
      wait_end();
      err_at = -1; to_at = -1;
    end
    rnd_mode = 0;

    base = nwrites;
    dv = 16'($urandom); l = 8'($urandom);
    f = 8'($urandom); ie = 8'($urandom);
    push_seq(dv, l, f, ie, 3);
    do_start(dv, l, f, ie);
    k = 0;
    while (nwrites < base + 1 && k < 100) begin
      @(negedge clk_i); k++;
    end
    start_i = 1; div_i = ~dv; lcr_i = ~l;
    fcr_i = ~f; ier_i = ~ie;
    @(negedge clk_i);
    start_i = 0;
    k = 0;
    while (nwrites < base + 3 && k < 100) begin
      @(negedge clk_i); k++;
    end
    chk("mid_writes", nwrites - base, 3);
    rst_i = 1;
    chk("rst_log", exp_q.size(), 0);
    exp_q.delete();
    push_seq(16'd27, 8'h03, 8'h07, 8'h01, 6);
    push_out(0, 0, 12);
    @(negedge clk_i);
    chk_rst();
    @(negedge clk_i);
    rst_i = 0;
    wait_end();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
